// File: rtl/wrapper_block_addr_gen_pkg.sv
// Shared packet geometry helpers and sequencer state type for the wrapper
// block address generator.
package wrapper_block_addr_gen_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  function automatic int packet_bytes(input int packet_width);
    return (packet_width + 7) / 8;
  endfunction

  function automatic int packet_byte_width(input int packet_width);
    return $clog2(packet_bytes(packet_width));
  endfunction

  function automatic int packet_space_width(input int addr_width, input int packet_width);
    return addr_width - packet_byte_width(packet_width);
  endfunction

endpackage

// File: rtl/wrapper_block_addr_gen_if.sv
// Descriptor and address-stream bundle between the block bookkeeping logic,
// the address sequencer and the packet engine.
interface wrapper_block_addr_gen_if
  import wrapper_block_addr_gen_pkg::*;
#(
  parameter int ADDRWIDTH   = 11,
  parameter int PACKETWIDTH = 256
);
  localparam int PACKETSPACEWIDTH = packet_space_width(ADDRWIDTH, PACKETWIDTH);

  logic [PACKETSPACEWIDTH:0] cmd_packet_count;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      flush;
  logic [ADDRWIDTH-1:0]      addr;
  logic                      addr_last;
  logic                      addr_valid;
  logic                      addr_ready;
  logic                      block_done;
  logic                      cmd_err;
  logic                      busy;

  modport master (
    output cmd_packet_count, cmd_valid, flush, addr_ready,
    input  cmd_ready, addr, addr_last, addr_valid, block_done, cmd_err, busy
  );

  modport slave (
    input  cmd_packet_count, cmd_valid, flush, addr_ready,
    output cmd_ready, addr, addr_last, addr_valid, block_done, cmd_err, busy
  );

endinterface

// File: rtl/wrapper_block_addr_gen.sv
// Block address sequencer: places each block so it ends at the top of the
// address space and streams one packet-aligned address per accepted beat.
module wrapper_block_addr_gen
  import wrapper_block_addr_gen_pkg::*;
#(
  parameter int ADDRWIDTH   = 11,
  parameter int PACKETWIDTH = 256
) (
  input  logic                     hclk,
  input  logic                     hreset,
  wrapper_block_addr_gen_if.slave  bus
);

  localparam int PACKETBYTES      = packet_bytes(PACKETWIDTH);
  localparam int PACKETBYTEWIDTH  = packet_byte_width(PACKETWIDTH);
  localparam int PACKETSPACEWIDTH = ADDRWIDTH - PACKETBYTEWIDTH;
  localparam int CNTW             = PACKETSPACEWIDTH + 1;

  localparam logic [ADDRWIDTH:0]   SPACE_TOP = (ADDRWIDTH+1)'(1) << ADDRWIDTH;
  localparam logic [ADDRWIDTH:0]   SPAN_STEP = (ADDRWIDTH+1)'(PACKETBYTES);
  localparam logic [ADDRWIDTH-1:0] ADDR_STEP = ADDRWIDTH'(PACKETBYTES);
  localparam logic [CNTW-1:0]      CNT_ONE   = CNTW'(1);
  localparam logic [CNTW-1:0]      CNT_FULL  = CNT_ONE << PACKETSPACEWIDTH;

  state_t                state_q, state_n;
  logic [ADDRWIDTH-1:0]  addr_q, addr_n;
  logic [CNTW-1:0]       remaining_q, remaining_n;
  logic                  valid_q, valid_n;
  logic                  last_q, last_n;
  logic                  ready_q, ready_n;
  logic                  done_q, done_n;
  logic                  err_q, err_n;
  logic                  busy_q, busy_n;

  logic [ADDRWIDTH:0]    block_span;
  logic [ADDRWIDTH-1:0]  start_addr;

  // Extra top bit lets a full-space block wrap cleanly to a start of zero.
  assign block_span = {{(ADDRWIDTH-PACKETSPACEWIDTH){1'b0}}, bus.cmd_packet_count} * SPAN_STEP;
  assign start_addr = ADDRWIDTH'(SPACE_TOP - block_span);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      addr_q      <= addr_n;
      remaining_q <= remaining_n;
      valid_q     <= valid_n;
      last_q      <= last_n;
      ready_q     <= ready_n;
      done_q      <= done_n;
      err_q       <= err_n;
      busy_q      <= busy_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    addr_n      = addr_q;
    remaining_n = remaining_q;
    valid_n     = valid_q;
    last_n      = last_q;
    ready_n     = ready_q;
    done_n      = 1'b0;
    err_n       = 1'b0;
    busy_n      = busy_q;

    unique case (state_q)
      IDLE: begin
        ready_n = 1'b1;
        valid_n = 1'b0;
        last_n  = 1'b0;
        busy_n  = 1'b0;
        if (bus.cmd_valid && ready_q) begin
          if (bus.cmd_packet_count == '0) begin
            done_n = 1'b1;
          end else if (bus.cmd_packet_count > CNT_FULL) begin
            done_n = 1'b1;
            err_n  = 1'b1;
          end else begin
            state_n     = ISSUE;
            addr_n      = start_addr;
            remaining_n = bus.cmd_packet_count;
            valid_n     = 1'b1;
            last_n      = (bus.cmd_packet_count == CNT_ONE);
            ready_n     = 1'b0;
            busy_n      = 1'b1;
          end
        end
      end

      ISSUE: begin
        // Flush wins over a simultaneous beat; that beat is still consumed.
        if (bus.flush || (valid_q && bus.addr_ready && remaining_q == CNT_ONE)) begin
          state_n = IDLE;
          valid_n = 1'b0;
          last_n  = 1'b0;
          ready_n = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else if (valid_q && bus.addr_ready) begin
          addr_n      = addr_q + ADDR_STEP;
          remaining_n = remaining_q - CNT_ONE;
          last_n      = (remaining_n == CNT_ONE);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.addr       = addr_q;
  assign bus.addr_last  = last_q;
  assign bus.addr_valid = valid_q;
  assign bus.cmd_ready  = ready_q;
  assign bus.block_done = done_q;
  assign bus.cmd_err    = err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_wrapper_block_addr_gen.sv
// Directed bench for the wrapper block address sequencer with default
// geometry (2 KiB space, 32-byte packets).
module tb_wrapper_block_addr_gen;

  logic hclk;
  logic hreset;
  int   checks;
  int   failures;

  wrapper_block_addr_gen_if #(.ADDRWIDTH(11), .PACKETWIDTH(256)) bus ();

  wrapper_block_addr_gen #(.ADDRWIDTH(11), .PACKETWIDTH(256)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic test_reset;
    logic [16:0] outs;
    hreset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_packet_count = '0;
    bus.flush = 1'b0;
    bus.addr_ready = 1'b0;
    #3;
    tick();
    tick();
    outs = {bus.addr, bus.addr_last, bus.addr_valid, bus.cmd_ready,
            bus.block_done, bus.cmd_err, bus.busy};
    checks++;
    if (outs !== 17'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got 0x%0h expected 0x0", outs);
    end
    hreset = 1'b0;
    tick();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_basic;
    logic [10:0] exp_addr;
    bus.cmd_packet_count = 7'd4;
    bus.cmd_valid = 1'b1;
    bus.addr_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_busy: got ready=%b busy=%b expected ready=0 busy=1",
               bus.cmd_ready, bus.busy);
    end
    for (int i = 0; i < 4; i++) begin
      exp_addr = 11'h780 + 11'(32 * i);
      checks++;
      if (bus.addr_valid !== 1'b1 || bus.addr !== exp_addr || bus.addr_last !== (i == 3)) begin
        failures++;
        $display("[TB] FAIL basic_beat%0d: got v=%b a=0x%0h l=%b expected v=1 a=0x%0h l=%b",
                 i, bus.addr_valid, bus.addr, bus.addr_last, exp_addr, (i == 3));
      end
      tick();
    end
    checks++;
    if (bus.addr_valid !== 1'b0 || bus.block_done !== 1'b1 || bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_done: got v=%b done=%b ready=%b expected v=0 done=1 ready=1",
               bus.addr_valid, bus.block_done, bus.cmd_ready);
    end
    tick();
    checks++;
    if (bus.block_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_done_width: got %b expected 0", bus.block_done);
    end
  endtask

  task automatic test_sizes;
    logic [6:0]  counts [2];
    logic [10:0] starts [2];
    logic [10:0] exp_addr;
    counts = '{7'd64, 7'd1};
    starts = '{11'h000, 11'h7E0};
    bus.addr_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.cmd_packet_count = counts[k];
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      for (int i = 0; i < int'(counts[k]); i++) begin
        exp_addr = starts[k] + 11'(32 * i);
        checks++;
        if (bus.addr_valid !== 1'b1 || bus.addr !== exp_addr ||
            bus.addr_last !== (i == int'(counts[k]) - 1)) begin
          failures++;
          $display("[TB] FAIL sizes_c%0d_beat%0d: got v=%b a=0x%0h l=%b expected v=1 a=0x%0h l=%b",
                   counts[k], i, bus.addr_valid, bus.addr, bus.addr_last, exp_addr,
                   (i == int'(counts[k]) - 1));
        end
        tick();
      end
      checks++;
      if (bus.addr_valid !== 1'b0 || bus.block_done !== 1'b1) begin
        failures++;
        $display("[TB] FAIL sizes_c%0d_done: got v=%b done=%b expected v=0 done=1",
                 counts[k], bus.addr_valid, bus.block_done);
      end
      tick();
    end
  endtask

  task automatic test_zero_overflow;
    bus.cmd_packet_count = 7'd0;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.addr_valid !== 1'b0 || bus.block_done !== 1'b1 || bus.cmd_err !== 1'b0 ||
        bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL zero_count: got v=%b done=%b err=%b ready=%b expected v=0 done=1 err=0 ready=1",
               bus.addr_valid, bus.block_done, bus.cmd_err, bus.cmd_ready);
    end
    tick();
    checks++;
    if (bus.block_done !== 1'b0 || bus.addr_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_after: got done=%b v=%b expected done=0 v=0",
               bus.block_done, bus.addr_valid);
    end
    bus.cmd_packet_count = 7'd65;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.addr_valid !== 1'b0 || bus.block_done !== 1'b1 || bus.cmd_err !== 1'b1 ||
        bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overflow_count: got v=%b done=%b err=%b busy=%b expected v=0 done=1 err=1 busy=0",
               bus.addr_valid, bus.block_done, bus.cmd_err, bus.busy);
    end
    tick();
    checks++;
    if (bus.block_done !== 1'b0 || bus.cmd_err !== 1'b0 || bus.addr_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overflow_after: got done=%b err=%b v=%b expected 0 0 0",
               bus.block_done, bus.cmd_err, bus.addr_valid);
    end
  endtask

  task automatic test_backpressure;
    logic        pattern [5];
    logic [10:0] exp_addr;
    int          taken;
    pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    taken = 0;
    bus.cmd_packet_count = 7'd3;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.addr_ready = pattern[c];
      exp_addr = 11'h7A0 + 11'(32 * taken);
      checks++;
      if (bus.addr_valid !== 1'b1 || bus.addr !== exp_addr || bus.addr_last !== (taken == 2)) begin
        failures++;
        $display("[TB] FAIL stall_cycle%0d: got v=%b a=0x%0h l=%b expected v=1 a=0x%0h l=%b",
                 c, bus.addr_valid, bus.addr, bus.addr_last, exp_addr, (taken == 2));
      end
      tick();
      if (pattern[c]) taken++;
    end
    checks++;
    if (bus.addr_valid !== 1'b0 || bus.block_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_done: got v=%b done=%b expected v=0 done=1",
               bus.addr_valid, bus.block_done);
    end
    bus.addr_ready = 1'b1;
    tick();
  endtask

  task automatic test_flush;
    logic [10:0] exp_addr;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.block_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_idle: got ready=%b done=%b expected ready=1 done=0",
               bus.cmd_ready, bus.block_done);
    end
    bus.cmd_packet_count = 7'd8;
    bus.cmd_valid = 1'b1;
    bus.addr_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_addr = 11'h700 + 11'(32 * i);
      checks++;
      if (bus.addr !== exp_addr || bus.addr_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL flush_beat%0d: got v=%b a=0x%0h expected v=1 a=0x%0h",
                 i, bus.addr_valid, bus.addr, exp_addr);
      end
      tick();
    end
    bus.addr_ready = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.addr_valid !== 1'b0 || bus.block_done !== 1'b1 || bus.busy !== 1'b0 ||
        bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_abort: got v=%b done=%b busy=%b ready=%b expected v=0 done=1 busy=0 ready=1",
               bus.addr_valid, bus.block_done, bus.busy, bus.cmd_ready);
    end
    bus.cmd_packet_count = 7'd2;
    bus.cmd_valid = 1'b1;
    bus.addr_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.addr_valid !== 1'b1 || bus.addr !== 11'h7C0 || bus.addr_last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_next0: got v=%b a=0x%0h l=%b expected v=1 a=0x7c0 l=0",
               bus.addr_valid, bus.addr, bus.addr_last);
    end
    tick();
    checks++;
    if (bus.addr_valid !== 1'b1 || bus.addr !== 11'h7E0 || bus.addr_last !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_next1: got v=%b a=0x%0h l=%b expected v=1 a=0x7e0 l=1",
               bus.addr_valid, bus.addr, bus.addr_last);
    end
    tick();
    checks++;
    if (bus.addr_valid !== 1'b0 || bus.block_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_next_done: got v=%b done=%b expected v=0 done=1",
               bus.addr_valid, bus.block_done);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    logic [16:0] outs;
    bus.cmd_packet_count = 7'd8;
    bus.cmd_valid = 1'b1;
    bus.addr_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.addr !== 11'h740 || bus.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_pre: got a=0x%0h busy=%b expected a=0x740 busy=1",
               bus.addr, bus.busy);
    end
    #2;
    hreset = 1'b1;
    #1;
    outs = {bus.addr, bus.addr_last, bus.addr_valid, bus.cmd_ready,
            bus.block_done, bus.cmd_err, bus.busy};
    checks++;
    if (outs !== 17'h0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got 0x%0h expected 0x0", outs);
    end
    tick();
    hreset = 1'b0;
    tick();
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.addr_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_release: got ready=%b v=%b expected ready=1 v=0",
               bus.cmd_ready, bus.addr_valid);
    end
    test_basic();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_sizes();
    test_zero_overflow();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
